// File: rtl/adder_response_misr.sv
// Output response analyser for the 4-bit ripple adder under test.
// It folds NPAT accepted responses into a MISR, then compares the result
// with the golden signature captured at start and reports pass or trojan_flag.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for start; signature/pat_count hold (debug after abort)
//  RUN   | resp_ready=1; each handshake advances the MISR and pat_count
//  CHECK | one cycle; compare the signature with the golden register
//  DONE  | done=1 with exactly one of pass / trojan_flag; waits for start
module adder_response_misr #(
    parameter int                 WIDTH = 5,
    parameter int                 SIG_W = 16,
    parameter logic [SIG_W-1:0]   POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED  = 16'hFFFF,
    parameter int                 NPAT  = 256,
    parameter int                 CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SIG_W-1:0]   golden_sig,
    input  logic               resp_valid,
    input  logic [WIDTH-1:0]   resp_data,
    output logic               resp_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               trojan_flag,
    output logic [SIG_W-1:0]   signature,
    output logic [CNT_W-1:0]   pat_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] NPAT_C = CNT_W'(NPAT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   golden_q, golden_d;
    logic               pass_q, pass_d;
    logic               flag_q, flag_d;

    logic [SIG_W-1:0]   data_ext;
    logic [SIG_W-1:0]   sig_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hs;

    // MISR step: shift, fold the feedback taps in when the MSB falls out, add the response
    always_comb begin
        data_ext              = '0;
        data_ext[WIDTH-1:0]   = resp_data;
        sig_next              = {sig_q[SIG_W-2:0], 1'b0}
                              ^ (sig_q[SIG_W-1] ? POLY : '0)
                              ^ data_ext;
    end

    assign cnt_inc = cnt_q + ONE_C;
    assign hs      = resp_valid & resp_ready;

    // Next-state and datapath update; abort overrides everything and discards a same-cycle handshake
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        flag_d   = flag_q;
        if (abort) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d  = S_RUN;
                        sig_d    = SEED;
                        cnt_d    = '0;
                        golden_d = golden_sig;
                        pass_d   = 1'b0;
                        flag_d   = 1'b0;
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        sig_d = sig_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == NPAT_C) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    pass_d  = (sig_q == golden_q);
                    flag_d  = (sig_q != golden_q);
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            flag_q   <= flag_d;
        end
    end

    assign resp_ready  = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign trojan_flag = flag_q;
    assign signature   = sig_q;
    assign pat_count   = cnt_q;

endmodule

// File: tb/tb_adder_response_misr.sv
// Bench for adder_response_misr: three instances (NPAT = 1, 2, 4) share one
// stimulus bus; sel picks the instance whose outputs are being checked.
module tb_adder_response_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] golden;
    logic        valid;
    logic [4:0]  data;

    logic        rdy  [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic        ps   [3];
    logic        tf   [3];
    logic [15:0] sig  [3];
    logic [15:0] cnt  [3];

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] stim[$];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        adder_response_misr #(
            .NPAT((k == 0) ? 1 : ((k == 1) ? 2 : 4))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start),
            .abort       (abort),
            .golden_sig  (golden),
            .resp_valid  (valid),
            .resp_data   (data),
            .resp_ready  (rdy[k]),
            .busy        (bsy[k]),
            .done        (dn[k]),
            .pass        (ps[k]),
            .trojan_flag (tf[k]),
            .signature   (sig[k]),
            .pat_count   (cnt[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Signature as repeated multiply-by-x modulo the degree-16 polynomial, plus the response
    function automatic logic [15:0] ref_sig();
        int unsigned s;
        s = 32'h0000FFFF;
        foreach (stim[i]) begin
            s = s * 2;
            if (s >= 32'h10000) s = s ^ 32'h00011021;
            s = s ^ 32'(stim[i]);
        end
        return s[15:0];
    endfunction

    task automatic go_idle();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Start a run on instance s, feed stim, then check CHECK and DONE cycles
    task automatic drive_run(input int s, input logic [15:0] g, input bit rnd,
                             input logic [15:0] exp_sig, input logic exp_pass);
        int idx;
        int cyc;
        start  = 1'b1;
        golden = g;
        @(negedge clk);
        start  = 1'b0;
        golden = 16'h0000;
        chk("start_busy", 16'(bsy[s]), 16'h1);
        chk("start_done_low", 16'(dn[s]), 16'h0);
        chk("start_seed", sig[s], 16'hFFFF);
        chk("start_count", cnt[s], 16'h0);
        idx = 0;
        cyc = 0;
        while (idx < stim.size() && cyc < 200) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                valid = 1'b0;
                data  = 5'($urandom);
            end else begin
                valid = 1'b1;
                data  = stim[idx];
            end
            start = rnd && ($urandom_range(0, 3) == 0);
            if (valid && rdy[s]) idx++;
            @(negedge clk);
            cyc++;
        end
        valid = 1'b0;
        start = 1'b0;
        if (idx < stim.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got %0d handshakes, expected %0d", idx, stim.size());
        end
        chk("check_busy", 16'(bsy[s]), 16'h1);
        chk("check_ready", 16'(rdy[s]), 16'h0);
        chk("check_done", 16'(dn[s]), 16'h0);
        @(negedge clk);
        chk("done", 16'(dn[s]), 16'h1);
        chk("done_busy", 16'(bsy[s]), 16'h0);
        chk("signature", sig[s], exp_sig);
        chk("pass", 16'(ps[s]), 16'(exp_pass));
        chk("trojan_flag", 16'(tf[s]), 16'(!exp_pass));
        chk("pat_count", cnt[s], 16'(stim.size()));
    endtask

    typedef struct {
        int          sel;
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [15:0] gold;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 5'h00, 5'h00, 16'hEFDF, 16'hEFDF, 1'b1};
        tbl[1] = '{0, 5'h1F, 5'h00, 16'hEFDF, 16'hEFC0, 1'b0};
        tbl[2] = '{0, 5'h0A, 5'h00, 16'hEFD5, 16'hEFD5, 1'b1};
        tbl[3] = '{1, 5'h00, 5'h1F, 16'hEFDF, 16'hCF80, 1'b0};
        tbl[4] = '{1, 5'h1F, 5'h00, 16'hCFA1, 16'hCFA1, 1'b1};
        tbl[5] = '{1, 5'h00, 5'h00, 16'h0000, 16'hCF9F, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b1;
        abort  = 1'b0;
        golden = 16'h1234;
        valid  = 1'b1;
        data   = 5'h1F;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_sig", sig[s], 16'hFFFF);
            chk("rst_cnt", cnt[s], 16'h0);
            chk("rst_ready", 16'(rdy[s]), 16'h0);
            chk("rst_flags", 16'({bsy[s], dn[s], ps[s], tf[s]}), 16'h0);
        end
        start  = 1'b0;
        valid  = 1'b0;
        golden = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of directed single/double-response runs
        for (int i = 0; i < 6; i++) begin
            go_idle();
            stim.delete();
            stim.push_back(tbl[i].d0);
            if (tbl[i].sel == 1) stim.push_back(tbl[i].d1);
            drive_run(tbl[i].sel, tbl[i].gold, 1'b0, tbl[i].exp_sig, tbl[i].exp_pass);
        end

        // Valid gaps 1,0,0,1 on NPAT=2: same result as back-to-back
        go_idle();
        start = 1'b1; golden = 16'hEFDF;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1; data = 5'h00;
        @(negedge clk);
        valid = 1'b0; data = 5'h1F;
        @(negedge clk);
        @(negedge clk);
        chk("gap_hold_cnt", cnt[1], 16'h1);
        chk("gap_hold_sig", sig[1], 16'hEFDF);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("gap_check_busy", 16'(bsy[1]), 16'h1);
        @(negedge clk);
        chk("gap_done", 16'(dn[1]), 16'h1);
        chk("gap_sig", sig[1], 16'hCF80);
        chk("gap_flag", 16'(tf[1]), 16'h1);
        chk("gap_pass", 16'(ps[1]), 16'h0);
        chk("gap_cnt", cnt[1], 16'h2);

        // Abort in RUN after 1 of 4 responses; same-cycle handshake discarded
        go_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1; data = 5'h03;
        @(negedge clk);
        data  = 5'h07; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; valid = 1'b0;
        chk("abort_ready", 16'(rdy[2]), 16'h0);
        chk("abort_done", 16'(dn[2]), 16'h0);
        chk("abort_busy", 16'(bsy[2]), 16'h0);
        chk("abort_cnt", cnt[2], 16'h1);
        chk("abort_sig", sig[2], 16'hEFDC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_sig", sig[2], 16'hFFFF);
        chk("restart_cnt", cnt[2], 16'h0);

        // start+abort together in DONE -> IDLE; then re-run from DONE
        go_idle();
        stim.delete(); stim.push_back(5'h00);
        drive_run(0, 16'hEFDF, 1'b0, 16'hEFDF, 1'b1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_done", 16'(dn[0]), 16'h0);
        chk("sa_busy", 16'(bsy[0]), 16'h0);
        chk("sa_pass", 16'(ps[0]), 16'h0);
        chk("sa_sig_hold", sig[0], 16'hEFDF);
        stim.delete(); stim.push_back(5'h1F);
        drive_run(0, 16'hEFDF, 1'b0, 16'hEFC0, 1'b0);
        stim.delete(); stim.push_back(5'h0A);
        drive_run(0, 16'hEFD5, 1'b0, 16'hEFD5, 1'b1);

        // Randomized NPAT=4 runs with gaps and ignored mid-run starts
        for (int r = 0; r < 20; r++) begin
            logic [15:0] m;
            logic [15:0] g;
            bit          want;
            go_idle();
            stim.delete();
            for (int j = 0; j < 4; j++) stim.push_back(5'($urandom));
            m    = ref_sig();
            want = ($urandom_range(0, 1) == 1);
            g    = want ? m : (m ^ (16'h1 << $urandom_range(0, 15)));
            drive_run(2, g, 1'b1, m, want);
        end

        // Reset asserted mid-run
        go_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1; data = 5'h11;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sig", sig[2], 16'hFFFF);
        chk("midrst_cnt", cnt[2], 16'h0);
        chk("midrst_flags", 16'({rdy[2], bsy[2], dn[2], ps[2], tf[2]}), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
